// File: rtl/fifo_pkg.sv
// fifo_pkg: shared read-mode enum and error-flag bit positions for the FIFO controller
package fifo_pkg;
  typedef enum logic {STD, FWFT} fifo_mode_e;
  localparam int unsigned ERR_OVF = 0;
  localparam int unsigned ERR_UDF = 1;
endpackage

// File: rtl/simple_dual_one_clock.sv
// simple_dual_one_clock: single-clock dual-port SRAM with one write port and a registered read port
module simple_dual_one_clock #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
)(
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with standard or first-word-fall-through reads, programmable thresholds and error flags
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int FWFT       = 0
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic [ADDR_WIDTH:0]   free_count,
  input  logic [ADDR_WIDTH:0]   prog_full_thresh,
  input  logic [ADDR_WIDTH:0]   prog_empty_thresh,
  output logic                  prog_full,
  output logic                  prog_empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic [1:0]            err_sticky,
  input  logic                  err_clr
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? fifo_pkg::FWFT : fifo_pkg::STD;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  empty_q, wr_acc, rd_acc, ram_rd, valid_nxt;
  logic [CW-1:0]         count_nxt, ram_words;
  function automatic logic [ADDR_WIDTH-1:0] inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction
  assign empty = (MODE == fifo_pkg::FWFT) ? ~rd_valid : empty_q;
  // In FWFT the head word stays counted until popped, so RAM-resident words exclude it
  always_comb begin
    wr_acc    = wr_en & ~full;
    rd_acc    = rd_en & ~empty;
    ram_words = data_count - CW'(rd_valid);
    ram_rd    = (MODE == fifo_pkg::FWFT) ? (ram_words != '0) & (~rd_valid | rd_acc) : rd_acc;
    valid_nxt = (MODE == fifo_pkg::FWFT) ? ram_rd | (rd_valid & ~rd_acc) : rd_acc;
    count_nxt = rst ? '0 : data_count + CW'(wr_acc) - CW'(rd_acc);
  end
  always_ff @(posedge clk) begin
    data_count <= count_nxt;
    free_count <= DEPTH_C - count_nxt;
    full       <= count_nxt == DEPTH_C;
    empty_q    <= count_nxt == '0;
    prog_full  <= count_nxt >= prog_full_thresh;
    prog_empty <= count_nxt <= prog_empty_thresh;
    overflow   <= ~rst & wr_en & full;
    underflow  <= ~rst & rd_en & empty;
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid   <= 1'b0;
      err_sticky <= '0;
    end else begin
      if (wr_acc) wr_ptr <= inc(wr_ptr);
      if (ram_rd) rd_ptr <= inc(rd_ptr);
      rd_valid            <= valid_nxt;
      err_sticky[ERR_OVF] <= (err_sticky[ERR_OVF] & ~err_clr) | (wr_en & full);
      err_sticky[ERR_UDF] <= (err_sticky[ERR_UDF] & ~err_clr) | (rd_en & empty);
    end
  end
  simple_dual_one_clock #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_ram (
    .clk(clk),
    .wr_en(wr_acc),
    .wr_addr(wr_ptr),
    .wr_data(wr_data),
    .rd_en(ram_rd),
    .rd_addr(rd_ptr),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: directed checks of a standard-mode and an FWFT-mode FIFO instance side by side
`define CHK(tag, obs, exp) begin checks++; assert ((obs) === (exp)) else begin errors++; $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp); end end
module tb_sync_fifo_fwft;
  localparam int DW = 8, DEPTH = 5, CW = $clog2(DEPTH) + 1;
  logic clk = 0, rst = 1, err_clr = 0;
  logic s_wr = 0, s_rd = 0, f_wr = 0, f_rd = 0;
  logic [DW-1:0] wr_data = '0;
  logic [CW-1:0] pf_th = 4, pe_th = 1;
  logic [DW-1:0] s_q, f_q;
  logic s_v, s_full, s_empty, s_pf, s_pe, s_ovf, s_udf;
  logic f_v, f_full, f_empty, f_pf, f_pe, f_ovf, f_udf;
  logic [CW-1:0] s_cnt, s_free, f_cnt, f_free;
  logic [1:0] s_err, f_err;
  int checks = 0, errors = 0;
  int popped = 0, gaps = 0, bad = 0;
  always #5 clk = ~clk;
  sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr), .wr_data(wr_data), .rd_en(s_rd),
    .rd_data(s_q), .rd_valid(s_v), .full(s_full), .empty(s_empty),
    .data_count(s_cnt), .free_count(s_free),
    .prog_full_thresh(pf_th), .prog_empty_thresh(pe_th),
    .prog_full(s_pf), .prog_empty(s_pe), .overflow(s_ovf), .underflow(s_udf),
    .err_sticky(s_err), .err_clr(err_clr)
  );
  sync_fifo_fwft #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(f_wr), .wr_data(wr_data), .rd_en(f_rd),
    .rd_data(f_q), .rd_valid(f_v), .full(f_full), .empty(f_empty),
    .data_count(f_cnt), .free_count(f_free),
    .prog_full_thresh(pf_th), .prog_empty_thresh(pe_th),
    .prog_full(f_pf), .prog_empty(f_pe), .overflow(f_ovf), .underflow(f_udf),
    .err_sticky(f_err), .err_clr(err_clr)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    step(); step(); rst = 0;
    `CHK("rst_full", s_full, 1'b0)
    `CHK("rst_empty", s_empty, 1'b1)
    `CHK("rst_cnt", s_cnt, 4'd0)
    `CHK("rst_free", s_free, 4'd5)
    `CHK("rst_pe", s_pe, 1'b1)
    `CHK("rst_pf", s_pf, 1'b0)
    `CHK("rst_valid", s_v, 1'b0)
    `CHK("rst_err", s_err, 2'b00)
    `CHK("rst_ovf", s_ovf, 1'b0)
    `CHK("rst_f_empty", f_empty, 1'b1)
    `CHK("rst_f_valid", f_v, 1'b0)
    `CHK("rst_f_free", f_free, 4'd5)
    for (int i = 0; i < 5; i++) begin
      s_wr = 1; wr_data = DW'(8'hA0 + i); step();
      `CHK("fill_cnt", s_cnt, CW'(i + 1))
      `CHK("fill_pe", s_pe, i < 1)
      `CHK("fill_pf", s_pf, i >= 3)
      `CHK("fill_full", s_full, i == 4)
    end
    `CHK("fill_free", s_free, 4'd0)
    wr_data = 8'hEE; step();
    `CHK("ovf_pulse", s_ovf, 1'b1)
    `CHK("ovf_sticky", s_err, 2'b01)
    `CHK("ovf_cnt", s_cnt, 4'd5)
    s_wr = 0; step();
    `CHK("ovf_end", s_ovf, 1'b0)
    `CHK("ovf_sticky_hold", s_err, 2'b01)
    s_wr = 1; s_rd = 1; wr_data = 8'hBB; step();
    `CHK("full_wr_rd_ovf", s_ovf, 1'b1)
    `CHK("full_wr_rd_valid", s_v, 1'b1)
    `CHK("full_wr_rd_data", s_q, 8'hA0)
    `CHK("full_wr_rd_cnt", s_cnt, 4'd4)
    `CHK("full_wr_rd_full", s_full, 1'b0)
    s_wr = 0; step();
    `CHK("rd1_data", s_q, 8'hA1)
    `CHK("rd1_cnt", s_cnt, 4'd3)
    s_wr = 1; wr_data = 8'hA5; step();
    `CHK("cnt3_wr_rd_data", s_q, 8'hA2)
    `CHK("cnt3_wr_rd_cnt", s_cnt, 4'd3)
    s_wr = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      `CHK("drain_data", s_q, DW'(8'hA3 + i))
      `CHK("drain_valid", s_v, 1'b1)
    end
    s_rd = 0; step();
    `CHK("drain_valid_pulse", s_v, 1'b0)
    `CHK("drain_hold", s_q, 8'hA5)
    `CHK("drain_empty", s_empty, 1'b1)
    `CHK("drain_cnt", s_cnt, 4'd0)
    `CHK("drain_free", s_free, 4'd5)
    s_wr = 1; wr_data = 8'hC0; step();
    s_wr = 0; s_rd = 1; step();
    `CHK("wrap_data", s_q, 8'hC0)
    `CHK("wrap_valid", s_v, 1'b1)
    s_rd = 0; err_clr = 1; step(); err_clr = 0;
    `CHK("clr_sticky", s_err, 2'b00)
    s_rd = 1; step();
    `CHK("udf_pulse", s_udf, 1'b1)
    `CHK("udf_sticky", s_err, 2'b10)
    s_rd = 0; step();
    `CHK("udf_end", s_udf, 1'b0)
    err_clr = 1; s_rd = 1; step();
    `CHK("clr_vs_udf", s_err, 2'b10)
    s_rd = 0; step(); err_clr = 0;
    `CHK("clr_final", s_err, 2'b00)
    s_wr = 1; wr_data = 8'h11; step();
    `CHK("th_pe_cnt1", s_pe, 1'b1)
    step();
    `CHK("th_pe_cnt2", s_pe, 1'b0)
    `CHK("th_pf_cnt2", s_pf, 1'b0)
    s_wr = 0; pf_th = 2;
    `CHK("th_pf_before", s_pf, 1'b0)
    step();
    `CHK("th_pf_after", s_pf, 1'b1)
    pf_th = 4; step();
    `CHK("th_pf_restore", s_pf, 1'b0)
    f_wr = 1; wr_data = 8'h55; step();
    `CHK("fwft_n1_valid", f_v, 1'b0)
    `CHK("fwft_n1_cnt", f_cnt, 4'd1)
    f_wr = 0; step();
    `CHK("fwft_n2_valid", f_v, 1'b1)
    `CHK("fwft_n2_data", f_q, 8'h55)
    `CHK("fwft_n2_empty", f_empty, 1'b0)
    f_rd = 1; step();
    `CHK("fwft_pop_valid", f_v, 1'b0)
    `CHK("fwft_pop_cnt", f_cnt, 4'd0)
    `CHK("fwft_pop_udf", f_udf, 1'b0)
    step();
    `CHK("fwft_udf", f_udf, 1'b1)
    f_rd = 0; step();
    `CHK("fwft_udf_end", f_udf, 1'b0)
    for (int i = 0; i < 104; i++) begin
      f_wr = i < 100; wr_data = DW'(i);
      f_rd = f_v;
      if (f_v) begin
        if (f_q !== DW'(popped)) bad++;
        popped++;
      end else if (i >= 2 && i <= 101) gaps++;
      step();
    end
    f_rd = 0; f_wr = 0;
    `CHK("stream_popped", popped, 100)
    `CHK("stream_gaps", gaps, 0)
    `CHK("stream_order", bad, 0)
    `CHK("stream_empty", f_empty, 1'b1)
    f_wr = 1; wr_data = 8'h77; step();
    f_wr = 0; rst = 1; step(); rst = 0;
    `CHK("rstmid_valid", f_v, 1'b0)
    `CHK("rstmid_empty", f_empty, 1'b1)
    `CHK("rstmid_cnt", f_cnt, 4'd0)
    `CHK("rstmid_free", f_free, 4'd5)
    step();
    `CHK("rstmid_no_stale", f_v, 1'b0)
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
